// File: rtl/psum_accumulator.sv
`timescale 1ns/1ps
// Partial-sum accumulator: sums per-input-channel beats into an
// output-channel total and queues completed words in a 2-entry FIFO.
module psum_accumulator #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        psum_valid,
   input  logic [2*DATA_WIDTH-1:0]     psum,
   input  logic [7:0]                  in_ch_sel,
   input  logic [7:0]                  out_ch_sel,
   input  logic [7:0]                  last_in_ch,
   input  logic                        relu_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_WIDTH-1:0]        out_data,
   output logic [7:0]                  out_ch,
   output logic                        overflow,
   output logic                        seq_err
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] ext;
   logic [ACC_WIDTH-1:0] nxt;
   logic [ACC_WIDTH-1:0] word;
   logic [7:0]           cur_ch;
   logic                 active;

   logic [ACC_WIDTH-1:0] head_data;
   logic [ACC_WIDTH-1:0] tail_data;
   logic [7:0]           head_ch;
   logic [7:0]           tail_ch;
   logic [1:0]           count;

   logic first;
   logic complete;
   logic bad;
   logic full;
   logic pop;
   logic push;

   assign ext      = {{(ACC_WIDTH-PW){psum[PW-1]}}, psum};
   assign first    = (in_ch_sel == 8'd0);
   assign nxt      = first ? ext : acc + ext;
   assign word     = (relu_en && nxt[ACC_WIDTH-1]) ? '0 : nxt;
   assign complete = psum_valid && (in_ch_sel == last_in_ch);
   assign bad      = psum_valid && !first &&
                     (!active || out_ch_sel != cur_ch ||
                      in_ch_sel > last_in_ch);

   assign out_valid = (count != 2'd0);
   assign out_data  = head_data;
   assign out_ch    = head_ch;
   assign full      = (count == 2'd2);
   assign pop       = out_valid && out_ready;
   assign push      = complete && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cur_ch   <= '0;
         active   <= 1'b0;
         overflow <= 1'b0;
         seq_err  <= 1'b0;
      end else begin
         if (psum_valid) begin
            acc <= nxt;
            if (first) begin
               cur_ch <= out_ch_sel;
               active <= 1'b1;
            end
            // completion wins, so last_in_ch==0 never leaves active set
            if (complete)
               active <= 1'b0;
         end
         if (bad)
            seq_err <= 1'b1;
         if (complete && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_data <= '0;
         head_ch   <= '0;
         tail_data <= '0;
         tail_ch   <= '0;
         count     <= 2'd0;
      end else begin
         unique case (1'b1)
            push && pop: begin
               if (full) begin
                  head_data <= tail_data;
                  head_ch   <= tail_ch;
                  tail_data <= word;
                  tail_ch   <= out_ch_sel;
               end else begin
                  head_data <= word;
                  head_ch   <= out_ch_sel;
               end
            end
            push && !pop: begin
               if (count == 2'd0) begin
                  head_data <= word;
                  head_ch   <= out_ch_sel;
               end else begin
                  tail_data <= word;
                  tail_ch   <= out_ch_sel;
               end
               count <= count + 2'd1;
            end
            pop && !push: begin
               if (full) begin
                  head_data <= tail_data;
                  head_ch   <= tail_ch;
               end
               count <= count - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the element width; incoming partial sum is DATA_WIDTH*2 bits signed.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, giving the accumulator and output width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port psum_valid  input  1  partial-sum beat present this cycle.
REQ-006 SHALL have port psum  input  DATA_WIDTH*2  signed partial sum from the 8-lane compute engine.
REQ-007 SHALL have port in_ch_sel  input  8  input-channel index tagged on the beat.
REQ-008 SHALL have port out_ch_sel  input  8  output-channel index tagged on the beat.
REQ-009 SHALL have port last_in_ch  input  8  index of final input channel; quasi-static per layer.
REQ-010 SHALL have port relu_en  input  1  apply ReLU to completed sums.
REQ-011 SHALL have port out_valid  output  1  output FIFO head valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts head.
REQ-013 SHALL have port out_data  output  ACC_WIDTH  completed signed sum.
REQ-014 SHALL have port out_ch  output  8  output-channel index of out_data.
REQ-015 SHALL have port overflow  output  1  sticky: completed sum dropped, FIFO full.
REQ-016 SHALL have port seq_err  output  1  sticky: channel sequence violation.

Function
REQ-017 SHALL sign-extend psum to ACC_WIDTH before any addition.
REQ-018 SHALL, on psum_valid with in_ch_sel==0, load acc with sext(psum), latch out_ch_sel into cur_ch, set active.
REQ-019 SHALL, on psum_valid with in_ch_sel!=0, set acc = acc + sext(psum), wrapping modulo 2^ACC_WIDTH, no saturation.
REQ-020 SHALL, on psum_valid with in_ch_sel!=0 and (active==0 or out_ch_sel!=cur_ch), set seq_err and still accumulate per REQ-019.
REQ-021 SHALL, on psum_valid with in_ch_sel==last_in_ch, form completed = value acc would take this cycle (REQ-018/019), push it with out_ch_sel into the output FIFO, and clear active; last_in_ch==0 completes every beat.
REQ-022 SHALL apply ReLU (negative -> 0) to completed at push time when relu_en==1; otherwise pass unchanged.
REQ-023 SHALL implement the output FIFO as 2 entries, first-in first-out; out_data/out_ch/out_valid driven from head register.
REQ-024 SHALL show a pushed word at out_valid on the cycle after the completing beat (latency 1).
REQ-025 SHALL pop the head when out_valid && out_ready; out_data/out_ch SHALL hold stable while out_valid && !out_ready.
REQ-026 SHALL accept a push when FIFO is full only if a pop occurs the same cycle; otherwise drop the word, set overflow, leave FIFO contents unchanged.
REQ-027 SHALL permit push and pop in the same cycle at any occupancy (0, 1, 2) with count unchanged when both occur and FIFO non-empty.
REQ-028 SHALL ignore all beat inputs when psum_valid==0; acc, cur_ch, active hold.
REQ-029 SHALL produce no push for beats with in_ch_sel>last_in_ch; these accumulate per REQ-019 and set seq_err.

Reset
REQ-030 SHALL, while rst==1 at a clock edge, set acc=0, cur_ch=0, active=0, FIFO empty, out_valid=0, out_data=0, out_ch=0, overflow=0, seq_err=0.
REQ-031 SHALL discard an in-progress accumulation on reset mid-sequence; first beat after reset with in_ch_sel!=0 sets seq_err.
REQ-032 SHALL clear overflow and seq_err only by reset.

Verification
REQ-033 SHALL cover: last_in_ch=3, out_ch 5, beats in_ch 0..3 psum 10,-3,7,100, out_ready=1 -> one word out_data=114, out_ch=5, out_valid 1 cycle after in_ch 3 beat.
REQ-034 SHALL cover: relu_en=1, last_in_ch=1, psums -200,50 -> out_data=0; relu_en=0 same stimulus -> out_data=-150 (0xFFFFFF6A).
REQ-035 SHALL cover: last_in_ch=0, out_ready=0, three beats psum 1,2,3 -> FIFO holds 1,2; overflow=1; then out_ready=1 -> outputs 1 then 2, out_valid drops.
REQ-036 SHALL cover: FIFO full, out_ready=1, completing beat same cycle -> no overflow, next outputs in order, count stays 2.
REQ-037 SHALL cover: last_in_ch=3, beats in_ch 0 (out_ch 2), in_ch 1 (out_ch 4) -> seq_err=1; rst pulse after in_ch 1 of a valid sequence -> no output, all outputs 0.
REQ-038 SHALL cover: ACC_WIDTH=16 override, accumulate 0x7FFF + 1 -> out_data=0x8000 (wrap).
